wb_stage_pipe: RTL and testbench
================================

Name: wb_stage_pipe

Overview:
Parametrised successor to the combinational write-back mux. It registers the MEM/WB boundary and selects one of four write-back sources. It sign- or zero-extends byte loads, then drives the register-file write port one cycle after capture. It also provides stall/flush control, a sticky halt, a retired-instruction counter and a sticky configuration-error flag. It sits between the memory stage and the register file, and its registered outputs also feed the forwarding unit.

Parameters:
N, 16, data width in bits (N >= 8)
RA_W, 3, register-file address width
CNT_W, 16, width of the retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  MEM stage presents a valid instruction
in_wr_en  in  1  instruction writes the register file
in_wr_addr  in  RA_W  destination register
in_wb_sel  in  2  source select: 00 execute, 01 memory, 10 PC+2, 11 immediate
in_byte  in  1  memory source is a byte load (low 8 bits of in_mem_data)
in_signed  in  1  byte load is sign-extended (else zero-extended)
in_halt  in  1  instruction is HALT
in_ex_data  in  N  execute-stage result
in_mem_data  in  N  memory read data
in_pc_plus2  in  N  PC+2 of the instruction
in_imm  in  N  immediate value
stall  in  1  hold the WB register contents
flush  in  1  squash the WB register contents
rf_wr_en  out  1  register-file write enable
rf_wr_addr  out  RA_W  register-file write address
rf_wr_data  out  N  register-file write data
wb_valid  out  1  WB register holds a valid instruction
halted  out  1  sticky: HALT has retired
retired  out  CNT_W  count of retired valid instructions
err  out  1  sticky configuration error

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: all outputs 0, namely rf_wr_en, rf_wr_addr, rf_wr_data, wb_valid, halted, retired and err.
- Source mux (combinational, pre-register):
  - sel 00: in_ex_data.
  - sel 01: in_mem_data, or its low byte extended to N bits when in_byte=1. Extension uses bit 7 when in_signed=1 and zeros when in_signed=0.
  - sel 10: in_pc_plus2.
  - sel 11: in_imm.
- Capture condition: cap = in_valid & ~halted.
- Register update priority at each rising clk (highest first):
  1. flush: wb_valid<=0, rf_wr_en<=0; addr/data don't-care (hold). flush wins over stall.
  2. stall: all WB registers hold. rf_wr_en stays as it was; the register file must tolerate a repeated write of the same value.
  3. Otherwise: wb_valid<=cap; rf_wr_en<=cap & in_wr_en; rf_wr_addr<=in_wr_addr; rf_wr_data<=mux result.
- Latency: exactly 1 cycle from input presentation to rf_wr_* outputs.
- retired: increments by 1 on each clk edge where wb_valid=1 and neither stall nor flush is asserted. It wraps modulo 2^CNT_W without saturating.
- halted: set on the edge where an instruction with in_halt=1 is captured (case 3 with cap=1).
  - Never cleared except by rst; flush does not clear it.
  - Once set, no further instructions are captured, so wb_valid and rf_wr_en fall to 0 on the next non-stalled edge.
  - A HALT with in_wr_en=1 still performs its write.
- err: set (sticky until rst) on any edge where cap=1 and (in_byte=1 while in_wb_sel!=01). The offending instruction is still captured using the normal mux result; in_byte is ignored for non-memory selects.
- rst mid-operation: all state clears immediately, regardless of clk, stall or flush. The first capture is possible on the first rising edge after rst deasserts.
- Inputs while in_valid=0 have no effect on anything except that the WB register loads invalid (wb_valid=0, rf_wr_en=0).

Test Plan:
1. Reset, then present sel 00, in_ex_data=16'h1234, wr_en=1, addr=5, valid=1 -> next cycle: rf_wr_en=1, addr=5, data=16'h1234, wb_valid=1; retired increments to 1 on the following edge.
2. Byte load of in_mem_data=16'h00F0, sel 01, in_byte=1. With in_signed=1 -> data=16'hFFF0. Repeated with in_signed=0 -> data=16'h00F0. Both cases: err=0.
3. Capture sel 10 (PC+2=16'h0040), then hold stall=1 for 3 cycles while inputs change -> rf_wr_data remains 16'h0040 and retired does not increment. Then assert stall=1 and flush=1 together -> wb_valid=0, rf_wr_en=0.
4. HALT with valid=1 and wr_en=0 -> halted=1 next cycle and stays 1. Subsequent valid instructions are ignored: rf_wr_en=0, and retired stops after the HALT retires. A flush afterwards leaves halted=1.
5. Present sel 11 with in_byte=1 -> data=in_imm and err=1 (sticky). Assert rst asynchronously mid-cycle -> all outputs 0 before the next clk edge.
6. Preload retired to 2^CNT_W-1 (run 65535 retirements with CNT_W=16), retire one more -> retired=0.

Source files
------------

// File: rtl/wb_stage_pipe.sv
// MEM/WB register with 4-way write-back source select, byte-load extension, sticky halt/err and retire counter.
// Latency 1 cycle to rf_wr_*; stall holds the WB register, flush squashes it and wins over stall.
module wb_stage_pipe #(
    parameter int N     = 16,
    parameter int RA_W  = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_wr_en,
    input  logic [RA_W-1:0]  in_wr_addr,
    input  logic [1:0]       in_wb_sel,
    input  logic             in_byte,
    input  logic             in_signed,
    input  logic             in_halt,
    input  logic [N-1:0]     in_ex_data,
    input  logic [N-1:0]     in_mem_data,
    input  logic [N-1:0]     in_pc_plus2,
    input  logic [N-1:0]     in_imm,
    input  logic             stall,
    input  logic             flush,
    output logic             rf_wr_en,
    output logic [RA_W-1:0]  rf_wr_addr,
    output logic [N-1:0]     rf_wr_data,
    output logic             wb_valid,
    output logic             halted,
    output logic [CNT_W-1:0] retired,
    output logic             err
);

    logic             r_wr_en;
    logic [RA_W-1:0]  r_wr_addr;
    logic [N-1:0]     r_wr_data;
    logic             r_valid;
    logic             r_halted;
    logic [CNT_W-1:0] r_retired;
    logic             r_err;

    logic [N-1:0]     w_mem_ext;
    logic [N-1:0]     w_mux;
    logic             w_cap;
    logic             w_bad_cfg;

    always_comb begin
        w_mem_ext = in_mem_data;
        if (in_byte) begin
            w_mem_ext = {{(N-8){in_signed & in_mem_data[7]}}, in_mem_data[7:0]};
        end
    end

    always_comb begin
        w_mux = in_ex_data;
        case (in_wb_sel)
            2'b00:   w_mux = in_ex_data;
            2'b01:   w_mux = w_mem_ext;
            2'b10:   w_mux = in_pc_plus2;
            default: w_mux = in_imm;
        endcase
    end

    assign w_cap     = in_valid & ~r_halted;
    // in_byte only has meaning for the memory source; anything else is a decode error.
    assign w_bad_cfg = w_cap & in_byte & (in_wb_sel != 2'b01);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_valid   <= 1'b0;
            r_halted  <= 1'b0;
            r_retired <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_bad_cfg) begin
                r_err <= 1'b1;
            end
            if (flush) begin
                r_valid <= 1'b0;
                r_wr_en <= 1'b0;
            end else if (!stall) begin
                r_valid   <= w_cap;
                r_wr_en   <= w_cap & in_wr_en;
                r_wr_addr <= in_wr_addr;
                r_wr_data <= w_mux;
                if (w_cap & in_halt) begin
                    r_halted <= 1'b1;
                end
            end
            // Retirement counts the instruction leaving WB, so a held or squashed one does not count.
            if (r_valid & ~stall & ~flush) begin
                r_retired <= r_retired + 1'b1;
            end
        end
    end

    assign rf_wr_en   = r_wr_en;
    assign rf_wr_addr = r_wr_addr;
    assign rf_wr_data = r_wr_data;
    assign wb_valid   = r_valid;
    assign halted     = r_halted;
    assign retired    = r_retired;
    assign err        = r_err;

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Directed-vector bench for wb_stage_pipe: stimulus queues hand-computed expectations, a monitor checks them after each edge.
module tb_wb_stage_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0, in_wr_en = 1'b0, in_byte = 1'b0, in_signed = 1'b0, in_halt = 1'b0;
    logic [2:0]  in_wr_addr = '0;
    logic [1:0]  in_wb_sel = '0;
    logic [15:0] in_ex_data = '0, in_mem_data = '0, in_pc_plus2 = '0, in_imm = '0;
    logic        stall = 1'b0, flush = 1'b0;
    logic        rf_wr_en, wb_valid, halted, err;
    logic [2:0]  rf_wr_addr;
    logic [15:0] rf_wr_data, retired;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic        en;
        logic        chk_ad;
        logic [2:0]  addr;
        logic [15:0] data;
        logic        vld;
        logic        hlt;
        logic        er;
        logic [15:0] ret;
    } exp_t;

    exp_t sb[$];

    wb_stage_pipe #(.N(16), .RA_W(3), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_wr_en(in_wr_en), .in_wr_addr(in_wr_addr),
        .in_wb_sel(in_wb_sel), .in_byte(in_byte), .in_signed(in_signed), .in_halt(in_halt),
        .in_ex_data(in_ex_data), .in_mem_data(in_mem_data), .in_pc_plus2(in_pc_plus2), .in_imm(in_imm),
        .stall(stall), .flush(flush),
        .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
        .wb_valid(wb_valid), .halted(halted), .retired(retired), .err(err)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input string field, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s.%s actual=%h required=%h", name, field, act, req);
        end
    endtask

    task automatic check_zero(input string name);
        cmp(name, "rf_wr_en", {31'd0, rf_wr_en}, 32'd0);
        cmp(name, "rf_wr_addr", {29'd0, rf_wr_addr}, 32'd0);
        cmp(name, "rf_wr_data", {16'd0, rf_wr_data}, 32'd0);
        cmp(name, "wb_valid", {31'd0, wb_valid}, 32'd0);
        cmp(name, "halted", {31'd0, halted}, 32'd0);
        cmp(name, "retired", {16'd0, retired}, 32'd0);
        cmp(name, "err", {31'd0, err}, 32'd0);
    endtask

    // Push the state expected right after the coming rising edge, then advance to the next falling edge.
    task automatic chk(input string name, input logic en, input logic chk_ad, input logic [2:0] addr,
                       input logic [15:0] data, input logic vld, input logic hlt, input logic er,
                       input logic [15:0] ret);
        exp_t e;
        e.name = name; e.en = en; e.chk_ad = chk_ad; e.addr = addr; e.data = data;
        e.vld = vld; e.hlt = hlt; e.er = er; e.ret = ret;
        sb.push_back(e);
        @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                cmp(e.name, "rf_wr_en", {31'd0, rf_wr_en}, {31'd0, e.en});
                cmp(e.name, "wb_valid", {31'd0, wb_valid}, {31'd0, e.vld});
                cmp(e.name, "halted", {31'd0, halted}, {31'd0, e.hlt});
                cmp(e.name, "err", {31'd0, err}, {31'd0, e.er});
                cmp(e.name, "retired", {16'd0, retired}, {16'd0, e.ret});
                if (e.chk_ad) begin
                    cmp(e.name, "rf_wr_addr", {29'd0, rf_wr_addr}, {29'd0, e.addr});
                    cmp(e.name, "rf_wr_data", {16'd0, rf_wr_data}, {16'd0, e.data});
                end
            end
        end
    end

    initial begin : watchdog
        repeat (80000) @(posedge clk);
        failures++;
        $display("FAIL watchdog cycle budget expired actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        #1 rst = 1'b1;
        #2 check_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // 1: execute source
        in_valid = 1; in_wr_en = 1; in_wr_addr = 3'd5; in_wb_sel = 2'b00; in_ex_data = 16'h1234;
        chk("t1_ex", 1, 1, 3'd5, 16'h1234, 1, 0, 0, 16'd0);
        in_valid = 0;
        chk("t1_retire", 0, 0, 3'd0, 16'h0, 0, 0, 0, 16'd1);

        // 2: byte loads and a full-word load
        in_valid = 1; in_wr_addr = 3'd2; in_wb_sel = 2'b01; in_byte = 1; in_signed = 1; in_mem_data = 16'h00F0;
        chk("t2_sext", 1, 1, 3'd2, 16'hFFF0, 1, 0, 0, 16'd1);
        in_signed = 0; in_wr_addr = 3'd3;
        chk("t2_zext", 1, 1, 3'd3, 16'h00F0, 1, 0, 0, 16'd2);
        in_byte = 0; in_wr_addr = 3'd4; in_mem_data = 16'hABCD;
        chk("t2_word", 1, 1, 3'd4, 16'hABCD, 1, 0, 0, 16'd3);
        in_byte = 1; in_signed = 1; in_wr_addr = 3'd1; in_mem_data = 16'h1234;
        chk("t2_sext_pos", 1, 1, 3'd1, 16'h0034, 1, 0, 0, 16'd4);

        // 3: PC+2, stall for three cycles while inputs change, then stall+flush
        in_byte = 0; in_signed = 0; in_wb_sel = 2'b10; in_pc_plus2 = 16'h0040; in_wr_addr = 3'd6;
        chk("t3_pc", 1, 1, 3'd6, 16'h0040, 1, 0, 0, 16'd5);
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            in_pc_plus2 = 16'h0099 + 16'(i); in_wr_addr = 3'(i); in_wb_sel = 2'(i);
            chk("t3_stall", 1, 1, 3'd6, 16'h0040, 1, 0, 0, 16'd5);
        end
        flush = 1;
        chk("t3_stall_flush", 0, 0, 3'd0, 16'h0, 0, 0, 0, 16'd5);
        stall = 0; flush = 0; in_valid = 0;
        chk("t3_idle", 0, 0, 3'd0, 16'h0, 0, 0, 0, 16'd5);
        in_valid = 1; in_wr_en = 0; in_wb_sel = 2'b11; in_imm = 16'h5555; in_wr_addr = 3'd7;
        chk("t3_nowrite", 0, 1, 3'd7, 16'h5555, 1, 0, 0, 16'd5);

        // 4: HALT without write, later instructions ignored, flush keeps halted
        in_halt = 1; in_wb_sel = 2'b00; in_ex_data = 16'h7777; in_wr_addr = 3'd2;
        chk("t4_halt", 0, 1, 3'd2, 16'h7777, 1, 1, 0, 16'd6);
        in_halt = 0; in_wr_en = 1; in_ex_data = 16'h1111; in_wr_addr = 3'd1;
        chk("t4_ignored1", 0, 0, 3'd0, 16'h0, 0, 1, 0, 16'd7);
        chk("t4_ignored2", 0, 0, 3'd0, 16'h0, 0, 1, 0, 16'd7);
        flush = 1;
        chk("t4_flush", 0, 0, 3'd0, 16'h0, 0, 1, 0, 16'd7);
        flush = 0; in_valid = 0;
        rst = 1;
        #1 check_zero("t4_rst");
        @(negedge clk);
        rst = 0;

        // 5: immediate with stray in_byte sets err; HALT with write; async reset mid-cycle
        in_valid = 1; in_wr_en = 1; in_wb_sel = 2'b11; in_byte = 1; in_imm = 16'h0BEE; in_wr_addr = 3'd2;
        chk("t5_err", 1, 1, 3'd2, 16'h0BEE, 1, 0, 1, 16'd0);
        in_valid = 0; in_byte = 0;
        chk("t5_err_sticky", 0, 0, 3'd0, 16'h0, 0, 0, 1, 16'd1);
        in_valid = 1; in_halt = 1; in_wb_sel = 2'b00; in_ex_data = 16'h4242; in_wr_addr = 3'd3;
        chk("t5_halt_wr", 1, 1, 3'd3, 16'h4242, 1, 1, 1, 16'd1);
        in_valid = 0; in_halt = 0;
        chk("t5_halt_retire", 0, 0, 3'd0, 16'h0, 0, 1, 1, 16'd2);
        #2 rst = 1;
        #1 check_zero("t5_async_rst");
        @(negedge clk);
        rst = 0;

        // 6: counter wrap
        in_valid = 1; in_wr_en = 0; in_wb_sel = 2'b00;
        repeat (65535) @(negedge clk);
        chk("t6_max", 0, 0, 3'd0, 16'h0, 1, 0, 0, 16'hFFFF);
        chk("t6_wrap", 0, 0, 3'd0, 16'h0, 1, 0, 0, 16'h0000);
        in_valid = 0;

        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
